cv32e40p_x_rsp_arbiter: RTL and testbench

CV32E40P_X_RSP_ARBITER -- requirements
Module: cv32e40p_x_rsp_arbiter

---
 rtl/cv32e40p_x_rsp_arbiter.sv | 141 ++++++++++++++
 tb/tb_cv32e40p_x_rsp_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_x_rsp_arbiter.sv
// Merges accelerator responses from NumRsp sources into one X-response
// channel. Responses are only accepted while offloaded instructions are
// outstanding. Sources are granted round-robin and the result is held in a
// single output register.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   issue_valid_i/ready_o   offload handshake (one expected response each)
//   src_valid_i/ready_o     per-source response handshake
//   src_rd_i/data_i/error_i per-source response payload
//   x_p_valid_o/x_q_ready_i merged response handshake
//   x_p_rd_o/data_o/error_o merged response payload (registered)
//   busy_o                  outstanding work or held response
//   err_sticky_o            an error response has reached the core
module cv32e40p_x_rsp_arbiter #(
  parameter int unsigned NumRsp         = 2,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  logic [NumRsp-1:0]      src_valid_i,
  output logic [NumRsp-1:0]      src_ready_o,
  input  logic [NumRsp-1:0][4:0] src_rd_i,
  input  logic [NumRsp-1:0][31:0] src_data_i,
  input  logic [NumRsp-1:0]      src_error_i,
  output logic                   x_p_valid_o,
  input  logic                   x_q_ready_i,
  output logic [4:0]             x_p_rd_o,
  output logic [31:0]            x_p_data_o,
  output logic                   x_p_error_o,
  output logic                   busy_o,
  output logic                   err_sticky_o
);

  localparam int unsigned IdxW = (NumRsp > 1) ? $clog2(NumRsp) : 1;
  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumRsp - 1);

  logic [CntW-1:0] count_q, count_d;
  logic [IdxW-1:0] last_grant_q, last_grant_d;
  logic            valid_q, valid_d;
  logic [4:0]      rd_q, rd_d;
  logic [31:0]     data_q, data_d;
  logic            err_q, err_d;
  logic            sticky_q, sticky_d;

  logic            out_hs;
  logic            issue_hs;
  logic            out_free;
  logic            gnt_found;
  logic [IdxW-1:0] gnt_idx;
  logic [IdxW-1:0] cand;
  logic            accept;

  assign out_hs        = valid_q & x_q_ready_i;
  assign issue_ready_o = (count_q < MaxCnt) | out_hs;
  assign issue_hs      = issue_valid_i & issue_ready_o;
  assign out_free      = ~valid_q | out_hs;

  // Round-robin search starting just after the last granted source.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NumRsp; k++) begin
      cand = IdxW'((32'(last_grant_q) + k) % NumRsp);
      if (!gnt_found && src_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Spurious responses (nothing outstanding) are stalled, never consumed.
  assign accept = gnt_found & out_free & (count_q != '0);

  always_comb begin
    src_ready_o = '0;
    if (accept) src_ready_o[gnt_idx] = 1'b1;
  end

  // Outstanding counter; simultaneous issue and retire cancel out.
  always_comb begin
    count_d = count_q;
    if (issue_hs && !out_hs && (count_q < MaxCnt)) begin
      count_d = count_q + CntW'(1);
    end else if (out_hs && !issue_hs && (count_q != '0)) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Output register: reload from the granted source, else drain on handshake.
  always_comb begin
    valid_d      = valid_q;
    rd_d         = rd_q;
    data_d       = data_q;
    err_d        = err_q;
    last_grant_d = last_grant_q;
    sticky_d     = sticky_q | (out_hs & err_q);
    if (accept) begin
      valid_d      = 1'b1;
      rd_d         = src_rd_i[gnt_idx];
      data_d       = src_data_i[gnt_idx];
      err_d        = src_error_i[gnt_idx];
      last_grant_d = gnt_idx;
    end else if (out_free) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q      <= '0;
      last_grant_q <= LastIdx;
      valid_q      <= 1'b0;
      rd_q         <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      valid_q      <= valid_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
      err_q        <= err_d;
      sticky_q     <= sticky_d;
    end
  end

  assign x_p_valid_o  = valid_q;
  assign x_p_rd_o     = rd_q;
  assign x_p_data_o   = data_q;
  assign x_p_error_o  = err_q;
  assign err_sticky_o = sticky_q;
  assign busy_o       = (count_q != '0) | valid_q;

endmodule

// File: tb/tb_cv32e40p_x_rsp_arbiter.sv
// Self-checking bench for cv32e40p_x_rsp_arbiter: vector table, directed
// multi-cycle sequences and a randomized run against a reference model.
module tb_cv32e40p_x_rsp_arbiter;

  localparam int NR   = 2;
  localparam int MAXO = 4;
  localparam int IW   = $clog2(NR);

  logic                clk = 1'b0;
  logic                rst;
  logic                issue_valid;
  logic                issue_ready;
  logic [NR-1:0]       src_valid;
  logic [NR-1:0]       src_ready;
  logic [NR-1:0][4:0]  src_rd;
  logic [NR-1:0][31:0] src_data;
  logic [NR-1:0]       src_err;
  logic                xv;
  logic                x_ready;
  logic [4:0]          x_rd;
  logic [31:0]         x_data;
  logic                x_err;
  logic                busy;
  logic                sticky;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cv32e40p_x_rsp_arbiter #(.NumRsp(NR), .MaxOutstanding(MAXO)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .src_valid_i(src_valid), .src_ready_o(src_ready),
    .src_rd_i(src_rd), .src_data_i(src_data), .src_error_i(src_err),
    .x_p_valid_o(xv), .x_q_ready_i(x_ready),
    .x_p_rd_o(x_rd), .x_p_data_o(x_data), .x_p_error_o(x_err),
    .busy_o(busy), .err_sticky_o(sticky)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_o(input string tag, input logic ir, input logic [NR-1:0] sr,
                          input logic v, input logic b);
    chk({tag, ".issue_ready"}, 32'(issue_ready), 32'(ir));
    chk({tag, ".src_ready"}, 32'(src_ready), 32'(sr));
    chk({tag, ".x_p_valid"}, 32'(xv), 32'(v));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  task automatic expect_pl(input string tag, input logic [4:0] rd, input logic [31:0] d,
                           input logic e);
    chk({tag, ".rd"}, 32'(x_rd), 32'(rd));
    chk({tag, ".data"}, x_data, d);
    chk({tag, ".error"}, 32'(x_err), 32'(e));
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic iv, input logic [NR-1:0] sv, input logic xr,
                       input logic [NR-1:0] er);
    @(negedge clk);
    issue_valid = iv;
    src_valid   = sv;
    x_ready     = xr;
    src_err     = er;
    #1;
  endtask

  task automatic set_fixed_payload();
    src_rd[0]   = 5'd5;
    src_data[0] = 32'hDEADBEEF;
    src_rd[1]   = 5'd9;
    src_data[1] = 32'h12345678;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    issue_valid = 1'b0;
    src_valid = '0;
    x_ready = 1'b0;
    src_err = '0;
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic          iv;
    logic [NR-1:0] sv;
    logic          xr;
    logic          e_ir;
    logic [NR-1:0] e_sr;
    logic          e_xv;
    logic [4:0]    e_rd;
    logic [31:0]   e_data;
    logic          e_busy;
  } vec_t;

  vec_t tbl[10];

  // Reference model state
  int          m_cnt, m_lg, m_g;
  logic        m_valid, m_err, m_sticky;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  initial begin
    logic          e_hs, e_ir, e_free, e_acc, e_busy;
    logic [NR-1:0] e_sr;

    rst = 1'b1;
    issue_valid = 1'b0;
    src_valid = '0;
    x_ready = 1'b0;
    src_err = '0;
    set_fixed_payload();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    expect_o("reset", 1'b1, '0, 1'b0, 1'b0);
    expect_pl("reset", 5'd0, 32'd0, 1'b0);
    chk("reset.sticky", 32'(sticky), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table: spurious stall, single response, round-robin pair
    //            iv    sv     xr    ir    sr     xv    rd     data          busy
    tbl[0] = '{1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 5'd0, 32'h0,        1'b0};
    tbl[1] = '{1'b1, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 5'd0, 32'h0,        1'b0};
    tbl[2] = '{1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 1'b0, 5'd0, 32'h0,        1'b1};
    tbl[3] = '{1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1};
    tbl[4] = '{1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 5'd0, 32'h0,        1'b0};
    tbl[5] = '{1'b1, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 5'd0, 32'h0,        1'b0};
    tbl[6] = '{1'b1, 2'b11, 1'b1, 1'b1, 2'b10, 1'b0, 5'd0, 32'h0,        1'b1};
    tbl[7] = '{1'b0, 2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 5'd9, 32'h12345678, 1'b1};
    tbl[8] = '{1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1};
    tbl[9] = '{1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 5'd0, 32'h0,        1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].iv, tbl[i].sv, tbl[i].xr, '0);
      expect_o($sformatf("tbl%0d", i), tbl[i].e_ir, tbl[i].e_sr, tbl[i].e_xv, tbl[i].e_busy);
      if (tbl[i].e_xv) expect_pl($sformatf("tbl%0d", i), tbl[i].e_rd, tbl[i].e_data, 1'b0);
    end

    // Round-robin with four outstanding, both sources always valid
    do_reset();
    repeat (4) drive(1'b1, 2'b00, 1'b1, '0);
    drive(1'b0, 2'b11, 1'b1, '0); expect_o("rrA", 1'b0, 2'b01, 1'b0, 1'b1);
    drive(1'b0, 2'b11, 1'b1, '0); expect_o("rrB", 1'b1, 2'b10, 1'b1, 1'b1);
    expect_pl("rrB", 5'd5, 32'hDEADBEEF, 1'b0);
    drive(1'b0, 2'b11, 1'b1, '0); expect_o("rrC", 1'b1, 2'b01, 1'b1, 1'b1);
    expect_pl("rrC", 5'd9, 32'h12345678, 1'b0);
    drive(1'b0, 2'b11, 1'b1, '0); expect_o("rrD", 1'b1, 2'b10, 1'b1, 1'b1);
    expect_pl("rrD", 5'd5, 32'hDEADBEEF, 1'b0);
    drive(1'b0, 2'b00, 1'b1, '0); expect_o("rrE", 1'b1, 2'b00, 1'b1, 1'b1);
    expect_pl("rrE", 5'd9, 32'h12345678, 1'b0);
    drive(1'b0, 2'b00, 1'b1, '0); expect_o("rrF", 1'b1, 2'b00, 1'b0, 1'b0);

    // Backpressure: held response stays put, src1 waits
    do_reset();
    repeat (2) drive(1'b1, 2'b00, 1'b0, '0);
    drive(1'b0, 2'b01, 1'b0, '0); expect_o("bp_ld", 1'b1, 2'b01, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 2'b10, 1'b0, '0);
      expect_o($sformatf("bp_hold%0d", i), 1'b1, 2'b00, 1'b1, 1'b1);
      expect_pl($sformatf("bp_hold%0d", i), 5'd5, 32'hDEADBEEF, 1'b0);
    end
    drive(1'b0, 2'b10, 1'b1, '0); expect_o("bp_rel", 1'b1, 2'b10, 1'b1, 1'b1);
    drive(1'b0, 2'b00, 1'b1, '0); expect_o("bp_src1", 1'b1, 2'b00, 1'b1, 1'b1);
    expect_pl("bp_src1", 5'd9, 32'h12345678, 1'b0);

    // Full: issue refused until a retire happens in the same cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b00, 1'b1, '0);
      chk($sformatf("full_iss%0d", i), 32'(issue_ready), 32'd1);
    end
    drive(1'b1, 2'b00, 1'b1, '0); expect_o("full_blk", 1'b0, 2'b00, 1'b0, 1'b1);
    drive(1'b0, 2'b01, 1'b1, '0); expect_o("full_ld", 1'b0, 2'b01, 1'b0, 1'b1);
    drive(1'b1, 2'b00, 1'b1, '0); expect_o("full_swap", 1'b1, 2'b00, 1'b1, 1'b1);
    drive(1'b0, 2'b00, 1'b1, '0); expect_o("full_after", 1'b0, 2'b00, 1'b0, 1'b1);

    // Spurious response then an error response reaching the core
    do_reset();
    drive(1'b0, 2'b01, 1'b1, '0); expect_o("spur", 1'b1, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 1'b1, '0);
    drive(1'b0, 2'b01, 1'b1, 2'b01); expect_o("err_ld", 1'b1, 2'b01, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b1, '0);
    expect_pl("err_out", 5'd5, 32'hDEADBEEF, 1'b1);
    chk("err_pre_sticky", 32'(sticky), 32'd0);
    drive(1'b0, 2'b00, 1'b1, '0); chk("err_sticky1", 32'(sticky), 32'd1);
    drive(1'b0, 2'b00, 1'b1, '0); chk("err_sticky2", 32'(sticky), 32'd1);

    // Reset in the middle of operation
    do_reset();
    repeat (3) drive(1'b1, 2'b00, 1'b0, '0);
    drive(1'b0, 2'b01, 1'b0, '0);
    drive(1'b0, 2'b11, 1'b0, '0); expect_o("mid_pre", 1'b1, 2'b00, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    expect_o("mid_rst", 1'b1, 2'b00, 1'b0, 1'b0);
    expect_pl("mid_rst", 5'd0, 32'd0, 1'b0);
    chk("mid_rst.sticky", 32'(sticky), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue_valid = 1'b1;
    src_valid = '0;
    x_ready = 1'b1;
    drive(1'b0, 2'b11, 1'b1, '0); expect_o("mid_post", 1'b1, 2'b01, 1'b0, 1'b1);

    // Randomized run against the reference model
    do_reset();
    m_cnt = 0; m_lg = NR - 1; m_valid = 1'b0; m_err = 1'b0; m_sticky = 1'b0;
    m_rd = '0; m_data = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      issue_valid = ($urandom_range(0, 99) < 45);
      src_valid   = NR'($urandom);
      x_ready     = ($urandom_range(0, 99) < 70);
      src_err     = NR'($urandom);
      for (int s = 0; s < NR; s++) begin
        src_rd[s]   = 5'($urandom);
        src_data[s] = $urandom;
      end
      #1;
      e_hs   = m_valid && x_ready;
      e_ir   = (m_cnt < MAXO) || e_hs;
      e_free = !m_valid || e_hs;
      m_g = -1;
      for (int j = 1; j <= NR; j++) begin
        if (m_g < 0 && src_valid[IW'((m_lg + j) % NR)]) m_g = (m_lg + j) % NR;
      end
      e_acc  = (m_g >= 0) && e_free && (m_cnt > 0);
      e_sr   = '0;
      if (e_acc) e_sr[IW'(m_g)] = 1'b1;
      e_busy = (m_cnt > 0) || m_valid;
      expect_o($sformatf("rnd%0d", cyc), e_ir, e_sr, m_valid, e_busy);
      if (m_valid) expect_pl($sformatf("rnd%0d", cyc), m_rd, m_data, m_err);
      chk($sformatf("rnd%0d.sticky", cyc), 32'(sticky), 32'(m_sticky));
      // advance the model by one clock
      if (issue_valid && e_ir) m_cnt++;
      if (e_hs) m_cnt--;
      if (m_cnt < 0) m_cnt = 0;
      if (m_cnt > MAXO) m_cnt = MAXO;
      if (e_hs && m_err) m_sticky = 1'b1;
      if (e_acc) begin
        m_valid = 1'b1;
        m_rd    = src_rd[IW'(m_g)];
        m_data  = src_data[IW'(m_g)];
        m_err   = src_err[IW'(m_g)];
        m_lg    = m_g;
      end else if (e_free) begin
        m_valid = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
